// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int ICACHE_INDEX_W    = 4;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_OFFSET_W   = 2;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_e;

    // Word-aligned backing-memory address of word 'word' inside line 'line_addr'.
    function automatic logic [31:0] refill_addr(input logic [27:0] line_addr,
                                                input logic [1:0]  word);
        return {line_addr, word, 2'b00};
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line storage: one synchronous write port, one asynchronous read port.
module icache_data_ram
    import inst_cache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [INDEX_W-1:0]         w_index,
    input  logic [ICACHE_OFFSET_W-1:0] w_offset,
    input  logic [31:0]                w_data,
    input  logic [INDEX_W-1:0]         r_index,
    input  logic [ICACHE_OFFSET_W-1:0] r_offset,
    output logic [31:0]                r_data
);

    localparam int DEPTH = (2 ** INDEX_W) * ICACHE_LINE_WORDS;

    logic [31:0] mem_r [0:DEPTH-1];

    // Refill writes one word per acknowledged memory beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[{w_index, w_offset}] <= w_data;
        end
    end

    assign r_data = mem_r[{r_index, r_offset}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with a 4-word line refill FSM.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic        flush_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    ic_state_e            state_r;
    ic_state_e            state_next_s;
    logic [27:0]          miss_line_r;
    logic [1:0]           cnt_r;
    logic                 drop_r;
    logic [LINES-1:0]     valid_r;
    logic [TAG_W-1:0]     tag_r [0:LINES-1];

    logic [INDEX_W-1:0]   lookup_index_s;
    logic [TAG_W-1:0]     lookup_tag_s;
    logic [1:0]           lookup_offset_s;
    logic [INDEX_W-1:0]   refill_index_s;
    logic [31:0]          ram_rdata_s;
    logic                 hit_s;
    logic                 ram_we_s;
    logic                 refill_done_s;
    logic                 start_miss_s;
    logic                 addr_lsb_unused_s;

    // Byte-lane bits of the fetch address play no part in the lookup.
    assign addr_lsb_unused_s = ^addr_i[1:0];

    assign lookup_offset_s = addr_i[3:2];
    assign lookup_index_s  = addr_i[3+INDEX_W:4];
    assign lookup_tag_s    = addr_i[31:4+INDEX_W];
    assign refill_index_s  = miss_line_r[INDEX_W-1:0];

    assign hit_s         = valid_r[lookup_index_s] && (tag_r[lookup_index_s] == lookup_tag_s);
    assign ram_we_s      = (state_r == IC_REFILL) && mem_ack_i && !rst;
    assign refill_done_s = ram_we_s && (cnt_r == 2'd3);

    icache_data_ram #(
        .INDEX_W (INDEX_W)
    ) u_data_ram (
        .clk      (clk),
        .we       (ram_we_s),
        .w_index  (refill_index_s),
        .w_offset (cnt_r),
        .w_data   (mem_rdata_i),
        .r_index  (lookup_index_s),
        .r_offset (lookup_offset_s),
        .r_data   (ram_rdata_s)
    );

    // Next-state and fetch/memory outputs; reset forces every output low immediately.
    always_comb begin
        state_next_s = state_r;
        data_o       = ZERO_WORD;
        stallreq_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = ZERO_WORD;
        start_miss_s = 1'b0;
        if (rst) begin
            state_next_s = IC_IDLE;
        end else begin
            case (state_r)
                IC_IDLE: begin
                    if (ce_i) begin
                        if (hit_s) begin
                            data_o = ram_rdata_s;
                        end else begin
                            stallreq_o   = 1'b1;
                            start_miss_s = 1'b1;
                            state_next_s = IC_REFILL;
                        end
                    end else begin
                        state_next_s = IC_IDLE;
                    end
                end
                IC_REFILL: begin
                    stallreq_o = 1'b1;
                    mem_req_o  = 1'b1;
                    mem_addr_o = refill_addr(miss_line_r, cnt_r);
                    if (refill_done_s) begin
                        state_next_s = IC_IDLE;
                    end else begin
                        state_next_s = IC_REFILL;
                    end
                end
                default: begin
                    state_next_s = IC_IDLE;
                end
            endcase
        end
    end

    // FSM state, captured miss line, word counter and drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IC_IDLE;
            miss_line_r <= 28'd0;
            cnt_r       <= 2'd0;
            drop_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IC_IDLE: begin
                    if (start_miss_s) begin
                        miss_line_r <= addr_i[31:4];
                        cnt_r       <= 2'd0;
                        drop_r      <= 1'b0;
                    end
                end
                IC_REFILL: begin
                    if (mem_ack_i) begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                    // A flush during refill poisons the line being filled.
                    if (refill_done_s) begin
                        drop_r <= 1'b0;
                    end else if (flush_i) begin
                        drop_r <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // Valid bits: flush wins over a completing refill so a flushed line stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
        end else if (flush_i) begin
            valid_r <= {LINES{1'b0}};
        end else if (refill_done_s && !drop_r) begin
            valid_r[refill_index_s] <= 1'b1;
        end
    end

    // Tag written once the last word of the line has arrived.
    always_ff @(posedge clk) begin
        if (refill_done_s) begin
            tag_r[refill_index_s] <= miss_line_r[27:INDEX_W];
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Randomised self-checking bench for inst_cache against a line-level cache model.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic        flush_i;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int n_cmp;
    int n_bad;

    // Model: which 16-byte line address each slot currently holds.
    bit          m_valid [16];
    logic [27:0] m_line  [16];

    inst_cache dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .addr_i      (addr_i),
        .flush_i     (flush_i),
        .data_o      (data_o),
        .stallreq_o  (stallreq_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'h0000_1000 + {a[31:2], 2'b00};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch of address a; memory waits w cycles before each ack; optional flush on refill word fw.
    task automatic run_fetch(input logic [31:0] a, input int w, input int fw);
        int  idx;
        bit  exp_hit;
        int  stalls;
        int  acks;
        int  waitc;
        bit  flushed;
        bit  done;
        bit  remiss;
        int  exp_stalls;
        logic [31:0] exp_maddr;
        idx     = int'(a[7:4]);
        exp_hit = m_valid[idx] && (m_line[idx] == a[31:4]);
        stalls = 0; acks = 0; waitc = 0; flushed = 1'b0; done = 1'b0; remiss = 1'b0;
        @(negedge clk);
        ce_i = 1'b1; addr_i = a; mem_ack_i = 1'b0; flush_i = 1'b0;
        #1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (!stallreq_o) begin
                done = 1'b1;
            end else begin
                stalls++;
                n_cmp++;
                if (data_o !== 32'h0) begin
                    n_bad++;
                    $display("FAIL stall_data addr=%h got=%h want=00000000", a, data_o);
                end
                if (mem_req_o) begin
                    exp_maddr = {a[31:4], 4'h0} + 32'(acks * 4);
                    n_cmp++;
                    if (mem_addr_o !== exp_maddr) begin
                        n_bad++;
                        $display("FAIL mem_addr addr=%h got=%h want=%h", a, mem_addr_o, exp_maddr);
                    end
                    if (acks == fw && !flushed) begin
                        flush_i = 1'b1;
                        flushed = 1'b1;
                    end
                    if (waitc == w) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = mem_val(mem_addr_o);
                        acks++;
                        waitc = 0;
                    end else begin
                        mem_ack_i   = 1'b0;
                        mem_rdata_i = $urandom;
                        waitc++;
                    end
                end else if (acks == 4) begin
                    // Dropped line: IDLE misses again right after the refill.
                    remiss = 1'b1;
                    done   = 1'b1;
                    ce_i   = 1'b0;
                end
                if (!done) begin
                    @(posedge clk);
                    #1;
                    mem_ack_i = 1'b0;
                    flush_i   = 1'b0;
                    @(negedge clk);
                    #1;
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout addr=%h stalls=%0d acks=%0d", a, stalls, acks);
            ce_i = 1'b0;
        end
        exp_stalls = exp_hit ? 0 : (1 + 4 * (w + 1) + (flushed ? 1 : 0));
        n_cmp++;
        if (stalls != exp_stalls) begin
            n_bad++;
            $display("FAIL stall_cycles addr=%h got=%0d want=%0d", a, stalls, exp_stalls);
        end
        if (flushed) begin
            model_clear();
            n_cmp++;
            if (!remiss) begin
                n_bad++;
                $display("FAIL remiss addr=%h got=0 want=1", a);
            end
        end else begin
            n_cmp++;
            if (data_o !== mem_val(a) || mem_req_o !== 1'b0) begin
                n_bad++;
                $display("FAIL hit_data addr=%h got=%h req=%b want=%h req=0", a, data_o, mem_req_o, mem_val(a));
            end
            m_valid[idx] = 1'b1;
            m_line[idx]  = a[31:4];
        end
    endtask

    task automatic idle_flush();
        @(negedge clk);
        ce_i = 1'b0; flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b1; addr_i = 32'h0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (data_o !== 32'h0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h/%b/%b/%h want=0/0/0/0", data_o, stallreq_o, mem_req_o, mem_addr_o);
        end
        @(negedge clk);
        ce_i = 1'b0; rst = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h0000_0000, 0, -1);
        run_fetch(32'h0000_0004, 0, -1);
        run_fetch(32'h0000_0008, 0, -1);
        run_fetch(32'h0000_000C, 0, -1);
    endtask

    task automatic test_slow_memory();
        run_fetch(32'h0000_0040, 3, -1);
        run_fetch(32'h0000_0048, 0, -1);
    endtask

    task automatic test_conflict();
        run_fetch(32'h0000_0000, 0, -1);
        run_fetch(32'h0000_0100, 1, -1);
        run_fetch(32'h0000_0000, 0, -1);
    endtask

    task automatic test_flush();
        run_fetch(32'h0000_0000, 0, -1);
        idle_flush();
        run_fetch(32'h0000_0000, 0, -1);
        run_fetch(32'h0000_0000, 0, 1);
        run_fetch(32'h0000_0000, 0, -1);
    endtask

    task automatic test_reset_mid_refill();
        idle_flush();
        @(negedge clk);
        ce_i = 1'b1; addr_i = 32'h0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mem_ack_i = 1'b1; mem_rdata_i = mem_val(32'(k * 4));
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
        end
        n_cmp++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin
            n_bad++;
            $display("FAIL pre_reset_req got=%b/%h want=1/00000008", mem_req_o, mem_addr_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0 || data_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_abort got=%b/%b/%h want=0/0/0", mem_req_o, stallreq_o, data_o);
        end
        @(negedge clk);
        rst = 1'b0; ce_i = 1'b0;
        model_clear();
        run_fetch(32'h0000_0000, 0, -1);
    endtask

    task automatic test_ce_off();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ce_i = 1'b0; addr_i = $urandom; mem_ack_i = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (data_o !== 32'h0 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
                n_bad++;
                $display("FAIL ce_off addr=%h got=%h/%b/%b want=0/0/0", addr_i, data_o, stallreq_o, mem_req_o);
            end
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        int w;
        int fw;
        for (int i = 0; i < 60; i++) begin
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            w  = $urandom_range(0, 2);
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 19) == 0) idle_flush();
            run_fetch(a, w, fw);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_cold_miss();
        test_slow_memory();
        test_conflict();
        test_flush();
        test_reset_mid_refill();
        test_ce_off();
        test_random();
        test_ce_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU's instruction-fetch port and a multi-cycle backing instruction memory.
- Fetch side: CPU rom_ce_o/rom_addr_o drive ce_i/addr_i; data_o feeds rom_data_i.
- On a hit, returns the word in the same cycle.
- On a miss, raises stallreq_o (OR-ed into ctrl's stall inputs) and refills a 4-word line from memory over a req/ack handshake.

Parameters:
- INDEX_W, 4, index width; number of lines = 2**INDEX_W (default 16 lines, 64 words).
- Line size is fixed at 4 words; offset = addr[3:2], index = addr[3+INDEX_W:4], tag = addr[31:4+INDEX_W].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ce_i  in  1  fetch enable from CPU.
- addr_i  in  32  fetch address (byte address; bits [1:0] ignored).
- flush_i  in  1  invalidate all lines.
- data_o  out  32  instruction word to CPU.
- stallreq_o  out  1  pipeline stall request to ctrl.
- mem_req_o  out  1  backing-memory read request.
- mem_addr_o  out  32  word-aligned backing-memory address.
- mem_rdata_i  in  32  backing-memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  backing-memory word accepted/returned this cycle.

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all valid bits 0; refill counter 0; drop flag 0.
  - Outputs: data_o=0, stallreq_o=0, mem_req_o=0, mem_addr_o=0.
  - Reset asserted mid-refill aborts the refill immediately; mem_req_o falls in the same cycle; partial line data is discarded (valid stays 0).
- ce_i=0: data_o=0, stallreq_o=0, no lookup, no refill started.
- Lookup (IDLE, ce_i=1) is combinational. hit = valid[index] && tag_ram[index]==tag.
  - Hit: data_o = line[index][offset]; stallreq_o=0.
  - Miss: data_o=0; stallreq_o=1 in the same cycle; next edge latches addr_i into miss_addr, sets cnt=0, enters REFILL.
- FSM states:
  - IDLE: serves hits; goes to REFILL on a miss.
  - REFILL: stallreq_o=1 throughout; mem_req_o=1; mem_addr_o = {miss_addr[31:4], cnt[1:0], 2'b00}.
    - On each cycle with mem_ack_i=1: write mem_rdata_i into line[index][cnt], then cnt++.
    - When the ack with cnt==3 arrives: write tag, set valid[index]=1 (unless drop flag is set), clear drop, return to IDLE.
- Handshake rules:
  - mem_req_o and mem_addr_o stay stable until ack.
  - Ack may arrive in the first REFILL cycle.
  - mem_ack_i outside REFILL is ignored.
- Latency:
  - Hit: 0 extra cycles.
  - Miss with ack every cycle: stallreq_o high for 5 cycles (1 miss cycle + 4 refill cycles); the following cycle hits.
  - General miss penalty: 1 + sum of per-word ack waits.
- CPU holds addr_i during stall; refill always uses miss_addr regardless of addr_i.
- Flush:
  - In IDLE: all valid bits cleared at the edge. In the flush cycle itself the lookup uses the pre-flush state.
  - In REFILL: valid bits cleared and the drop flag set. Refill completes but the line is left invalid. The FSM returns to IDLE, the next lookup misses and refetches.
- Conflict: a new miss to an index with a valid line overwrites tag and data (direct-mapped, no write-back).
- Wrap-around: cnt is 2 bits; offset sequence is always 0,1,2,3 from the line base. It is not critical-word-first.

Decomposition:
- defines.v gains:
  - `ICacheIndexW (4)
  - `ICacheLineWords (4)
  - `ICacheOffsetBus (1:0)
  - FSM state codes `ICIdle / `ICRefill
- Existing `RegBus, `InstAddrBus, `InstBus, `ZeroWord, `RstEnable are reused.
- One sub-module: icache_data_ram.
  - Holds the 2**INDEX_W x 4 x 32 storage.
  - One synchronous write port (index, offset, data, we) and one asynchronous read port (index, offset).
- Tag and valid arrays, the FSM and the counter stay in inst_cache.

Test Plan:
- Cold miss: rst, then ce_i=1, addr_i=0x00000000, memory acks every cycle returning 0x1000+4*k.
  - Expect stallreq_o=1 for 5 cycles and mem_addr_o 0x0,0x4,0x8,0xC.
  - Then data_o=0x1000 with stallreq_o=0.
  - addr_i 0x4/0x8/0xC then hit with 0x1004/0x1008/0x100C, no mem_req_o.
- Slow memory: miss at 0x00000040 with ack delayed 3 cycles per word.
  - Expect mem_addr_o stable during each wait.
  - stallreq_o high for 1+16 cycles; line then valid.
- Conflict: fill 0x00000000, then fetch 0x00000100 (same index 0, different tag).
  - Expect a miss and refill; fetching 0x00000000 again misses.
- Flush: with line 0 valid, pulse flush_i in IDLE; fetch 0x0 → miss.
  - Pulse flush_i during the 2nd refill word → refill finishes, the same address misses again next cycle.
- Reset mid-refill: assert rst after 2 acks.
  - Expect mem_req_o=0 and stallreq_o=0 immediately; after release, 0x0 misses.
- ce_i=0 with arbitrary addr_i → data_o=0, stallreq_o=0, mem_req_o=0.
